// File: rtl/modulus_seq_ctrl_if.sv
// Request/result handshake bundle for the sequential divider.
// master = requester/consumer side, slave = divider side.
interface modulus_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        is_32;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] remainder;
  logic [63:0] quotient;
  logic        div_by_zero;

  modport master (
    output in_valid, a, b, is_32, out_ready,
    input  in_ready, out_valid, remainder, quotient, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, is_32, out_ready,
    output in_ready, out_valid, remainder, quotient, div_by_zero
  );
endinterface

// File: rtl/modulus_seq_ctrl.sv
// Sequential unsigned divider: one restoring shift-subtract step per cycle,
// 64 steps for full-width operands, 32 steps in ALU32 mode.
module modulus_seq_ctrl (
  input  logic               clk,
  input  logic               rst,
  modulus_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] rem_reg;   // partial remainder, one spare bit for the shift
  logic [63:0] quo_reg;   // dividend bits shift out the top, quotient bits in the bottom
  logic [63:0] div_reg;
  logic        dbz_reg;

  logic [63:0] eff_a;
  logic [63:0] eff_b;
  logic [64:0] shifted;
  logic        sub_ok;
  logic [64:0] rem_step;

  // ALU32 mode zero-extends the low halves of both operands.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_eff
      if (gi < 32) begin : g_lo
        assign eff_a[gi] = bus.a[gi];
        assign eff_b[gi] = bus.b[gi];
      end else begin : g_hi
        assign eff_a[gi] = bus.a[gi] & ~bus.is_32;
        assign eff_b[gi] = bus.b[gi] & ~bus.is_32;
      end
    end
  endgenerate

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  // A set top bit would mean the shifted value already exceeds any divisor.
  always_comb begin
    shifted  = {rem_reg[63:0], quo_reg[63]};
    sub_ok   = rem_reg[64] | (shifted >= {1'b0, div_reg});
    rem_step = shifted;
    if (sub_ok) begin
      rem_step = shifted - {1'b0, div_reg};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      rem_reg   <= 65'd0;
      quo_reg   <= 64'd0;
      div_reg   <= 64'd0;
      dbz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            div_reg <= eff_b;
            if (eff_b == 64'd0) begin
              rem_reg   <= {1'b0, eff_a};
              quo_reg   <= 64'd0;
              dbz_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              rem_reg <= 65'd0;
              // In ALU32 mode the dividend is left-aligned so the same MSB-first
              // step works; the zeros below it leave bits [63:32] clear at the end.
              quo_reg   <= bus.is_32 ? {bus.a[31:0], 32'd0} : bus.a;
              cnt_reg   <= bus.is_32 ? 6'd31 : 6'd63;
              dbz_reg   <= 1'b0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= {quo_reg[62:0], sub_ok};
          if (cnt_reg == 6'd0) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 6'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.remainder   = rem_reg[63:0];
  assign bus.quotient    = quo_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_modulus_seq_ctrl.sv
// Directed bench for modulus_seq_ctrl. Latency is counted with the accept
// edge as cycle 1, so a zero divisor reports 1 and a 64-bit divide 65.
module tb_modulus_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  modulus_seq_ctrl_if bus_if ();

  modulus_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; out_ready stays low.
  task automatic do_req(input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic t32, output int lat);
    @(negedge clk);
    bus_if.a        = ta;
    bus_if.b        = tb_v;
    bus_if.is_32    = t32;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("req a=%h b=%h is_32=%0d latency=%0d rem=%h quo=%h dbz=%0d",
             ta, tb_v, t32, lat, bus_if.remainder, bus_if.quotient, bus_if.div_by_zero);
  endtask

  task automatic finish_hs();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus_if.in_ready); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus_if.out_valid); end
    checks++; if (bus_if.remainder !== 64'd0) begin errors++; $display("FAIL reset_rem got %h exp 0", bus_if.remainder); end
    checks++; if (bus_if.quotient !== 64'd0) begin errors++; $display("FAIL reset_quo got %h exp 0", bus_if.quotient); end
    checks++; if (bus_if.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", bus_if.div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_req(64'd100, 64'd7, 1'b0, lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL basic_latency got %0d exp 65", lat); end
    checks++; if (bus_if.remainder !== 64'd2) begin errors++; $display("FAIL basic_rem got %h exp 2", bus_if.remainder); end
    checks++; if (bus_if.quotient !== 64'd14) begin errors++; $display("FAIL basic_quo got %h exp 14", bus_if.quotient); end
    checks++; if (bus_if.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b exp 0", bus_if.div_by_zero); end
    checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b exp 0", bus_if.in_ready); end
    finish_hs();
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after got %b exp 0", bus_if.out_valid); end
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got %b exp 1", bus_if.in_ready); end
  endtask

  task automatic test_div_zero();
    int lat;
    do_req(64'hDEAD, 64'd0, 1'b0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
    checks++; if (bus_if.remainder !== 64'hDEAD) begin errors++; $display("FAIL dz_rem got %h exp dead", bus_if.remainder); end
    checks++; if (bus_if.quotient !== 64'd0) begin errors++; $display("FAIL dz_quo got %h exp 0", bus_if.quotient); end
    checks++; if (bus_if.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", bus_if.div_by_zero); end
    finish_hs();
    // ALU32 zero divisor: only the low half of b counts.
    do_req(64'h12345678_9ABCDEF0, 64'h0000ABCD_00000000, 1'b1, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz32_latency got %0d exp 1", lat); end
    checks++; if (bus_if.remainder !== 64'h00000000_9ABCDEF0) begin errors++; $display("FAIL dz32_rem got %h exp 9abcdef0", bus_if.remainder); end
    checks++; if (bus_if.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz32_flag got %b exp 1", bus_if.div_by_zero); end
    finish_hs();
  endtask

  task automatic test_alu32();
    int lat;
    do_req(64'hFFFFFFFF_00000009, 64'h00000001_00000004, 1'b1, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL alu32_latency got %0d exp 33", lat); end
    checks++; if (bus_if.remainder !== 64'd1) begin errors++; $display("FAIL alu32_rem got %h exp 1", bus_if.remainder); end
    checks++; if (bus_if.quotient !== 64'd2) begin errors++; $display("FAIL alu32_quo got %h exp 2", bus_if.quotient); end
    checks++; if (bus_if.div_by_zero !== 1'b0) begin errors++; $display("FAIL alu32_dbz got %b exp 0", bus_if.div_by_zero); end
    finish_hs();
    // Full 32-bit dividend: 0xFFFFFFFF / 0x10 = 0x0FFFFFFF r 0xF.
    do_req(64'hAAAAAAAA_FFFFFFFF, 64'h55555555_00000010, 1'b1, lat);
    checks++; if (bus_if.quotient !== 64'h00000000_0FFFFFFF) begin errors++; $display("FAIL alu32b_quo got %h exp 0fffffff", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 64'h0000000F) begin errors++; $display("FAIL alu32b_rem got %h exp f", bus_if.remainder); end
    finish_hs();
  endtask

  task automatic test_edge_values();
    int lat;
    do_req(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, lat);
    checks++; if (bus_if.quotient !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL b1_quo got %h exp ffffffffffffffff", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 64'd0) begin errors++; $display("FAIL b1_rem got %h exp 0", bus_if.remainder); end
    finish_hs();
    do_req(64'd5, 64'd9, 1'b0, lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL bgt_latency got %0d exp 65", lat); end
    checks++; if (bus_if.quotient !== 64'd0) begin errors++; $display("FAIL bgt_quo got %h exp 0", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 64'd5) begin errors++; $display("FAIL bgt_rem got %h exp 5", bus_if.remainder); end
    finish_hs();
    // Divisor with top bit set: 0xFFFFFFFF_FFFFFFFF / 0x80000000_00000000 = 1 r 0x7FFFFFFF_FFFFFFFF.
    do_req(64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000, 1'b0, lat);
    checks++; if (bus_if.quotient !== 64'd1) begin errors++; $display("FAIL big_quo got %h exp 1", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 64'h7FFFFFFF_FFFFFFFF) begin errors++; $display("FAIL big_rem got %h exp 7fffffffffffffff", bus_if.remainder); end
    finish_hs();
    do_req(64'd1000003, 64'd1000, 1'b0, lat);
    checks++; if (bus_if.quotient !== 64'd1000) begin errors++; $display("FAIL mid_quo got %h exp 3e8", bus_if.quotient); end
    checks++; if (bus_if.remainder !== 64'd3) begin errors++; $display("FAIL mid_rem got %h exp 3", bus_if.remainder); end
    finish_hs();
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(64'd100, 64'd7, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.a        = 64'd1000 + 64'(i);
      bus_if.b        = (i == 3) ? 64'd0 : 64'd3 + 64'(i);
      bus_if.is_32    = i[0];
      @(posedge clk);
      #1;
      checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", i, bus_if.out_valid); end
      checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, bus_if.in_ready); end
      checks++; if (bus_if.remainder !== 64'd2 || bus_if.quotient !== 64'd14 || bus_if.div_by_zero !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got rem=%h quo=%h dbz=%b exp rem=2 quo=e dbz=0",
                           i, bus_if.remainder, bus_if.quotient, bus_if.div_by_zero);
      end
    end
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", bus_if.in_ready); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", bus_if.out_valid); end
    $display("backpressure: 10 held cycles then release");
  endtask

  task automatic test_reset_abort();
    int lat;
    bit spurious;
    @(negedge clk);
    bus_if.a        = 64'd100;
    bus_if.b        = 64'd7;
    bus_if.is_32    = 1'b0;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b exp 1", bus_if.in_ready); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", bus_if.out_valid); end
    checks++; if (bus_if.quotient !== 64'd0 || bus_if.remainder !== 64'd0) begin
      errors++; $display("FAIL abort_clear got rem=%h quo=%h exp 0 0", bus_if.remainder, bus_if.quotient);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_if.out_ready = 1'b0;
    spurious = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid === 1'b1) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL abort_no_result got out_valid seen exp none"); end
    $display("reset abort on 20th CALC cycle");
    do_req(64'd100, 64'd7, 1'b0, lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL post_abort_latency got %0d exp 65", lat); end
    checks++; if (bus_if.remainder !== 64'd2) begin errors++; $display("FAIL post_abort_rem got %h exp 2", bus_if.remainder); end
    checks++; if (bus_if.quotient !== 64'd14) begin errors++; $display("FAIL post_abort_quo got %h exp e", bus_if.quotient); end
    finish_hs();
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = 64'd0;
    bus_if.b         = 64'd0;
    bus_if.is_32     = 1'b0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_alu32();
    test_edge_values();
    test_backpressure();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulus_seq_ctrl.md
MODULUS_SEQ_CTRL -- requirements
Module: modulus_seq_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  operand request valid.
REQ-004 in_ready  output  1  block can accept a request.
REQ-005 a  input  64  dividend.
REQ-006 b  input  64  divisor.
REQ-007 is_32  input  1  1 = ALU32 operation on a[31:0], b[31:0].
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 remainder  output  64  a mod b.
REQ-011 quotient  output  64  a div b.
REQ-012 div_by_zero  output  1  effective divisor was zero.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on a rising edge where state = IDLE and in_valid = 1; a, b and is_32 SHALL be captured on that edge and ignored thereafter.
REQ-016 With is_32 = 1, the effective operands SHALL be a[31:0] and b[31:0], zero-extended, and results SHALL have bits [63:32] = 0.
REQ-017 If the effective divisor is 0 on acceptance: next state DONE; remainder = effective dividend; quotient = 0; div_by_zero = 1.
REQ-018 Otherwise: next state CALC; iteration counter loaded with N-1 (N = 64, or 32 when is_32 = 1); div_by_zero = 0.
REQ-019 Each CALC cycle SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first; the partial remainder register SHALL be 65 bits wide to hold the shifted value without overflow.
REQ-020 CALC SHALL last exactly N cycles; on the edge ending the step with counter = 0, state SHALL move to DONE.
REQ-021 out_valid SHALL first be high N+1 cycles after the accept edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-022 In DONE, remainder, quotient and div_by_zero SHALL stay constant until the handshake completes.
REQ-023 DONE with out_ready = 1 SHALL return to IDLE on that edge; no new request is accepted in the same cycle (in_ready = 0 in DONE).
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-025 remainder and quotient SHALL be undefined outside DONE; only out_valid qualifies them.
REQ-026 Results SHALL equal unsigned a % b and a / b for every nonzero effective divisor, including b > a (q = 0, r = a) and b = 1 (q = a, r = 0).

Reset
REQ-027 While rst = 1 on an edge: state SHALL be IDLE, counter 0, out_valid 0, in_ready 1 after that edge, div_by_zero 0, remainder 0, quotient 0.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation without producing out_valid; the aborted result SHALL be discarded.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-030 a = 100, b = 7, is_32 = 0, out_ready = 1 -> out_valid exactly 65 cycles after accept; remainder = 2, quotient = 14, div_by_zero = 0.
REQ-031 a = 0xDEAD, b = 0 -> out_valid 1 cycle after accept; remainder = 0xDEAD, quotient = 0, div_by_zero = 1.
REQ-032 a = 0xFFFFFFFF_00000009, b = 0x00000001_00000004, is_32 = 1 -> out_valid 33 cycles after accept; remainder = 1, quotient = 2.
REQ-033 a = 0xFFFFFFFF_FFFFFFFF, b = 1 -> quotient = 0xFFFFFFFF_FFFFFFFF, remainder = 0; a = 5, b = 9 -> quotient = 0, remainder = 5.
REQ-034 out_ready held low 10 cycles in DONE, with in_valid = 1 and changing a, b -> outputs stable, in_ready = 0, no accept; out_ready = 1 -> IDLE next edge, then in_ready = 1.
REQ-035 rst pulsed on the 20th CALC cycle -> next cycle in_ready = 1, out_valid = 0; a fresh 100 mod 7 request then completes correctly with remainder = 2.
